add_share_arb: RTL and testbench

Round-robin scheduler that time-shares one instance of the team's 16-bit Brent-Kung prefix adder (`add`) between NREQ requesters, such as FIR tap-accumulation lanes. It accepts one operand pair per cycle through per-requester valid/ready handshakes. It registers the sum together with the winning requester's index in a single output stage that has backpressure. It sits between the tap multipliers and the accumulator or cascade stage of the filter.

---
 rtl/add_share_pkg.sv | 35 +++
 rtl/add.sv | 42 ++++
 rtl/add_share_arb_rr_arb.sv | 36 +++
 rtl/add_share_arb.sv | 100 ++++++++++
 tb/tb_add_share_arb.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_share_pkg.sv
// Shared types and the round-robin search function for the add_share_arb slice.
// Build option: ADD_SHARE_COUT_EN (registered carry-out port on add_share_arb).
package add_share_pkg;

  localparam int ADD_W   = 16;
  localparam int MAX_REQ = 8;

  typedef logic [ADD_W-1:0] add_word_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First valid index at or above ptr, searching cyclically over nreq requesters.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input int                 nreq);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < nreq) begin
        j = int'(ptr) + k;
        if (j >= nreq) j = j - nreq;
        if (!r.found && valid[3'(j)]) begin
          r.found = 1'b1;
          r.idx   = 3'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/add.sv
// 16-bit Brent-Kung parallel-prefix adder (up-sweep then down-sweep carry tree).
module add
  import add_share_pkg::*;
(
  input  add_word_t a,
  input  add_word_t b,
  input  logic      cin,
  output add_word_t sum
);

  add_word_t w_g;
  add_word_t w_p;
  add_word_t w_prop;

  always_comb begin
    int step;
    int half;
    w_prop = a ^ b;
    w_g    = a & b;
    w_p    = w_prop;
    // Fold the carry-in into bit 0 so the tree yields the carry out of each bit.
    w_g[0] = w_g[0] | (w_p[0] & cin);
    for (int d = 0; d < 4; d++) begin
      step = 2 << d;
      half = 1 << d;
      for (int i = step - 1; i < ADD_W; i += step) begin
        w_g[i] = w_g[i] | (w_p[i] & w_g[i-half]);
        w_p[i] = w_p[i] & w_p[i-half];
      end
    end
    for (int d = 2; d >= 0; d--) begin
      step = 2 << d;
      half = 1 << d;
      for (int i = 3 * half - 1; i < ADD_W; i += step) begin
        w_g[i] = w_g[i] | (w_p[i] & w_g[i-half]);
        w_p[i] = w_p[i] & w_p[i-half];
      end
    end
    sum = w_prop ^ {w_g[ADD_W-2:0], cin};
  end

endmodule

// File: rtl/add_share_arb_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant plus encoded index; pointer is owned by the caller.
module rr_arb
  import add_share_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [MAX_REQ-1:0] w_valid8;
  logic [2:0]         w_ptr3;
  rr_pick_t           w_pick;

  always_comb begin
    w_valid8               = '0;
    w_valid8[NREQ-1:0]     = req_valid;
    w_ptr3                 = '0;
    w_ptr3[IDW-1:0]        = rr_ptr;
    w_pick                 = rr_pick(w_valid8, w_ptr3, NREQ);
    grant                  = '0;
    grant_idx              = '0;
    // With no grant the index stays 0 so the operand mux parks on requester 0.
    for (int i = 0; i < NREQ; i++) begin
      if (enable && w_pick.found && (w_pick.idx == 3'(i))) begin
        grant[i]  = 1'b1;
        grant_idx = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/add_share_arb.sv
// Round-robin time-sharing of one 16-bit adder between NREQ requesters, single registered output stage.
// Build option: ADD_SHARE_COUT_EN adds the registered rsp_cout port.
module add_share_arb
  import add_share_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [ADD_W*NREQ-1:0] req_a,
  input  logic [ADD_W*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADD_W-1:0]      rsp_sum,
  output logic [IDW-1:0]        rsp_id
`ifdef ADD_SHARE_COUT_EN
  ,
  output logic                  rsp_cout
`endif
);

  logic            r_rspValid;
  add_word_t       r_rspSum;
  logic [IDW-1:0]  r_rspId;
  logic [IDW-1:0]  r_rrPtr;

  logic            w_canAcc;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gIdx;
  logic            w_xfer;
  add_word_t       w_opA;
  add_word_t       w_opB;
  add_word_t       w_sum;

  // Reset blocks acceptance so nothing is handshaken during the reset cycle.
  assign w_canAcc = (~r_rspValid | rsp_ready) & ~rst;

  rr_arb #(.NREQ(NREQ)) u_rr_arb (
    .req_valid (req_valid),
    .rr_ptr    (r_rrPtr),
    .enable    (w_canAcc),
    .grant     (w_grant),
    .grant_idx (w_gIdx)
  );

  assign req_ready = w_grant;
  assign w_xfer    = |w_grant;
  assign w_opA     = req_a[ADD_W*w_gIdx +: ADD_W];
  assign w_opB     = req_b[ADD_W*w_gIdx +: ADD_W];

  add u_add (
    .a   (w_opA),
    .b   (w_opB),
    .cin (1'b0),
    .sum (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rspValid <= 1'b0;
      r_rspSum   <= '0;
      r_rspId    <= '0;
      r_rrPtr    <= '0;
    end else if (w_xfer) begin
      r_rspValid <= 1'b1;
      r_rspSum   <= w_sum;
      r_rspId    <= w_gIdx;
      r_rrPtr    <= (w_gIdx == IDW'(NREQ - 1)) ? '0 : w_gIdx + 1'b1;
    end else if (rsp_ready) begin
      r_rspValid <= 1'b0;
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_sum   = r_rspSum;
  assign rsp_id    = r_rspId;

`ifdef ADD_SHARE_COUT_EN
  logic r_rspCout;
  logic w_cout;

  // The adder does not export its carry, so recover it from the operand and sum MSBs.
  assign w_cout = (w_opA[ADD_W-1] & w_opB[ADD_W-1]) |
                  ((w_opA[ADD_W-1] ^ w_opB[ADD_W-1]) & ~w_sum[ADD_W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rspCout <= 1'b0;
    end else if (w_xfer) begin
      r_rspCout <= w_cout;
    end
  end

  assign rsp_cout = r_rspCout;
`endif

endmodule

// File: tb/tb_add_share_arb.sv
// Self-checking bench for add_share_arb: scoreboard monitor plus directed scenario tasks.
module tb_add_share_arb;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_sum;
  logic [1:0]  rsp_id;
`ifdef ADD_SHARE_COUT_EN
  logic        rsp_cout;
`endif

  add_share_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
`ifdef ADD_SHARE_COUT_EN
    ,
    .rsp_cout  (rsp_cout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic        cout;
    logic [15:0] sum;
  } exp_t;

  exp_t       sbQ[$];
  int         nTests = 0;
  int         nFail  = 0;
  bit         monOn  = 1'b0;
  logic [1:0] mPtr   = '0;
  logic       mValid = 1'b0;

  // Reference model: predicts the grant from its own pointer, queues sums on accept, checks on output.
  always @(negedge clk) begin : monitor
    logic [3:0]  expRdy;
    logic [16:0] full;
    int          g;
    int          idx;
    exp_t        e;
    if (monOn) begin
      nTests++;
      if (rsp_valid !== mValid) begin
        nFail++;
        $display("[TB] FAIL mon_rsp_valid: got %b expected %b", rsp_valid, mValid);
      end
      if (mValid) begin
        nTests++;
        if (sbQ.size() == 0) begin
          nFail++;
          $display("[TB] FAIL mon_queue: result held but none expected");
        end else begin
          e = sbQ[0];
          if (rsp_sum !== e.sum || rsp_id !== e.id) begin
            nFail++;
            $display("[TB] FAIL mon_result: got sum=%h id=%0d expected sum=%h id=%0d",
                     rsp_sum, rsp_id, e.sum, e.id);
          end
`ifdef ADD_SHARE_COUT_EN
          nTests++;
          if (rsp_cout !== e.cout) begin
            nFail++;
            $display("[TB] FAIL mon_cout: got %b expected %b", rsp_cout, e.cout);
          end
`endif
        end
      end
      nTests++;
      if (rst) begin
        if (req_ready !== 4'b0000) begin
          nFail++;
          $display("[TB] FAIL mon_ready_rst: got %b expected 0000", req_ready);
        end
        sbQ.delete();
        mValid = 1'b0;
        mPtr   = '0;
      end else begin
        expRdy = '0;
        g      = -1;
        if (!mValid || rsp_ready) begin
          for (int k = 0; k < NREQ; k++) begin
            idx = (int'(mPtr) + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
          end
        end
        if (g >= 0) expRdy[g] = 1'b1;
        if (req_ready !== expRdy) begin
          nFail++;
          $display("[TB] FAIL mon_ready: got %b expected %b", req_ready, expRdy);
        end
        if (mValid && rsp_ready && sbQ.size() > 0) void'(sbQ.pop_front());
        if (g >= 0) begin
          full   = {1'b0, req_a[16*g +: 16]} + {1'b0, req_b[16*g +: 16]};
          e.id   = 2'(g);
          e.sum  = full[15:0];
          e.cout = full[16];
          sbQ.push_back(e);
          mPtr   = 2'((g + 1) % NREQ);
          mValid = 1'b1;
        end else if (rsp_ready) begin
          mValid = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic atNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic setOp(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic test_reset();
    req_valid = 4'b0001;
    setOp(0, 16'h0001, 16'h0002);
    rsp_ready = 1'b0;
    tick();
    nTests++;
    if (rsp_valid !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL reset_pre_valid: got %b expected 1", rsp_valid);
    end
    rst       = 1'b1;
    req_valid = 4'b1111;
    atNeg();
    nTests++;
    if (req_ready !== 4'b0000) begin
      nFail++;
      $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready);
    end
    tick();
    rst = 1'b0;
    nTests++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 16'h0000 || rsp_id !== 2'd0) begin
      nFail++;
      $display("[TB] FAIL reset_state: got valid=%b sum=%h id=%0d expected 0 0000 0",
               rsp_valid, rsp_sum, rsp_id);
    end
    rsp_ready = 1'b1;
    atNeg();
    nTests++;
    if (req_ready !== 4'b0001) begin
      nFail++;
      $display("[TB] FAIL reset_first_grant: got %b expected 0001", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    setOp(2, 16'h1234, 16'h0FFF);
    rsp_ready = 1'b1;
    atNeg();
    nTests++;
    if (req_ready !== 4'b0100) begin
      nFail++;
      $display("[TB] FAIL single_ready: got %b expected 0100", req_ready);
    end
    tick();
    req_valid = '0;
    nTests++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 16'h2233 || rsp_id !== 2'd2) begin
      nFail++;
      $display("[TB] FAIL single_result: got valid=%b sum=%h id=%0d expected 1 2233 2",
               rsp_valid, rsp_sum, rsp_id);
    end
    tick();
  endtask

  task automatic test_wrap();
    req_valid = 4'b0010;
    setOp(1, 16'hFFFF, 16'h0001);
    tick();
    req_valid = '0;
    nTests++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 16'h0000 || rsp_id !== 2'd1) begin
      nFail++;
      $display("[TB] FAIL wrap_result: got valid=%b sum=%h id=%0d expected 1 0000 1",
               rsp_valid, rsp_sum, rsp_id);
    end
`ifdef ADD_SHARE_COUT_EN
    nTests++;
    if (rsp_cout !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL wrap_cout: got %b expected 1", rsp_cout);
    end
`endif
    tick();
  endtask

  task automatic test_fairness();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) setOp(i, 16'(16'h1000 * i), 16'(i + 1));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      nTests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % NREQ)) begin
        nFail++;
        $display("[TB] FAIL fair_seq[%0d]: got valid=%b id=%0d expected 1 %0d",
                 k, rsp_valid, rsp_id, k % NREQ);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0001;
    setOp(0, 16'h0005, 16'h0006);
    rsp_ready = 1'b0;
    tick();
    req_valid = 4'b0010;
    setOp(1, 16'h0100, 16'h0200);
    for (int k = 0; k < 3; k++) begin
      atNeg();
      nTests++;
      if (req_ready !== 4'b0000) begin
        nFail++;
        $display("[TB] FAIL bp_ready[%0d]: got %b expected 0000", k, req_ready);
      end
      tick();
      nTests++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 16'h000B || rsp_id !== 2'd0) begin
        nFail++;
        $display("[TB] FAIL bp_hold[%0d]: got valid=%b sum=%h id=%0d expected 1 000b 0",
                 k, rsp_valid, rsp_sum, rsp_id);
      end
    end
    rsp_ready = 1'b1;
    atNeg();
    nTests++;
    if (req_ready !== 4'b0010) begin
      nFail++;
      $display("[TB] FAIL bp_release: got %b expected 0010", req_ready);
    end
    tick();
    req_valid = '0;
    nTests++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 16'h0300 || rsp_id !== 2'd1) begin
      nFail++;
      $display("[TB] FAIL bp_next: got valid=%b sum=%h id=%0d expected 1 0300 1",
               rsp_valid, rsp_sum, rsp_id);
    end
    tick();
  endtask

  task automatic test_pointer_hold();
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    setOp(1, 16'h0011, 16'h0022);
    tick();
    req_valid = '0;
    tick();
    tick();
    for (int i = 0; i < NREQ; i++) setOp(i, 16'(16'h0100 + i), 16'h0000);
    req_valid = 4'b1111;
    atNeg();
    nTests++;
    if (req_ready !== 4'b0100) begin
      nFail++;
      $display("[TB] FAIL ptr_hold_ready: got %b expected 0100", req_ready);
    end
    tick();
    req_valid = '0;
    nTests++;
    if (rsp_id !== 2'd2 || rsp_sum !== 16'h0102) begin
      nFail++;
      $display("[TB] FAIL ptr_hold_result: got id=%0d sum=%h expected 2 0102", rsp_id, rsp_sum);
    end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 200; k++) begin
      req_valid = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) setOp(i, 16'($urandom), 16'($urandom));
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    nTests++;
    if (sbQ.size() != 0 || rsp_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL rand_drain: got pending=%0d valid=%b expected 0 0", sbQ.size(), rsp_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst   = 1'b0;
    monOn = 1'b1;
    test_reset();
    test_single();
    test_wrap();
    test_fairness();
    test_backpressure();
    test_pointer_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
